// File: rtl/axi4_stream_pkg.sv
// Shared AXI4-Stream definitions: arbiter FSM states and the round-robin selector.
package axi4_stream_pkg;

   localparam int unsigned SN_MAX = 16;
   localparam int unsigned IDX_W  = $clog2(SN_MAX);

   typedef enum logic {
      StIdle,
      StLock
   } arb_state_e;

   // One-hot winner: first set bit of req after ptr, wrapping modulo sn.
   function automatic logic [SN_MAX-1:0] rr_sel(input logic [SN_MAX-1:0] req,
                                                input logic [IDX_W-1:0]  ptr,
                                                input int                sn);
      logic [SN_MAX-1:0] sel;
      logic [IDX_W:0]    idx;
      logic              found;
      sel   = '0;
      found = 1'b0;
      for (int i = 1; i <= int'(SN_MAX); i++) begin
         if (i <= sn) begin
            idx = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (idx >= (IDX_W + 1)'(sn)) idx = idx - (IDX_W + 1)'(sn);
            if (!found && req[idx[IDX_W-1:0]]) begin
               sel[idx[IDX_W-1:0]] = 1'b1;
               found               = 1'b1;
            end
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/axi4_stream_reg.sv
// Single-stage registered stream slice; upstream ready is passed through combinationally
// whenever the stage is empty or being drained.
module axi4_stream_reg
   import axi4_stream_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   input  logic         i_ready
);

   logic         r_valid;
   logic [W-1:0] r_data;

   assign o_ready = ~r_valid | i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_valid && o_ready) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/axi4_stream_arb.sv
// Packet-granular round-robin N:1 AXI4-Stream arbiter with a registered output stage.
module axi4_stream_arb
   import axi4_stream_pkg::*;
#(
   parameter int unsigned SN = 2,
   parameter int unsigned DN = 1,
   parameter int unsigned DW = 8
) (
   input  logic               ACLK,
   input  logic               ARESETn,
   input  logic [SN*DN*DW-1:0] sti_TDATA,
   input  logic [SN*DN-1:0]   sti_TKEEP,
   input  logic [SN-1:0]      sti_TLAST,
   input  logic [SN-1:0]      sti_TVALID,
   output logic [SN-1:0]      sti_TREADY,
   output logic [DN*DW-1:0]   sto_TDATA,
   output logic [DN-1:0]      sto_TKEEP,
   output logic               sto_TLAST,
   output logic               sto_TVALID,
   input  logic               sto_TREADY,
   input  logic [SN-1:0]      ctl_mask,
   output logic [SN-1:0]      sts_grant,
   output logic               sts_busy
);

   localparam int unsigned IW = $clog2(SN);
   localparam int unsigned BW = DN * DW;
   localparam int unsigned OW = BW + DN + 1;

   arb_state_e        r_state, w_state_nxt;
   logic [SN-1:0]     r_grant, w_grant_nxt;
   logic [IW-1:0]     r_ptr, w_ptr_nxt;

   logic [SN-1:0]     w_req, w_sel, w_hs;
   logic [IW-1:0]     w_sel_idx;
   logic [SN_MAX-1:0] w_req_ext, w_sel_ext;
   logic [IDX_W-1:0]  w_ptr_ext;
   logic              w_slot_rdy, w_xfer, w_xfer_last;
   logic [BW-1:0]     w_mux_data;
   logic [DN-1:0]     w_mux_keep;
   logic              w_mux_last;
   logic [OW-1:0]     w_out_data;

   assign w_req = sti_TVALID & ctl_mask;

   always_comb begin
      w_req_ext            = '0;
      w_req_ext[SN-1:0]    = w_req;
      w_ptr_ext            = '0;
      w_ptr_ext[IW-1:0]    = r_ptr;
   end

   assign w_sel_ext = rr_sel(w_req_ext, w_ptr_ext, int'(SN));
   assign w_sel     = w_sel_ext[SN-1:0];

   if (SN < SN_MAX) begin : g_sel_pad
      logic w_unused_sel;
      assign w_unused_sel = ^w_sel_ext[SN_MAX-1:SN];
   end

   always_comb begin
      w_sel_idx = '0;
      for (int i = 0; i < int'(SN); i++) begin
         if (w_sel[i]) w_sel_idx = IW'(i);
      end
   end

   // Only the granted source sees ready, and only when the output stage can take a beat.
   assign sti_TREADY  = r_grant & {SN{w_slot_rdy}};
   assign w_hs        = sti_TVALID & sti_TREADY;
   assign w_xfer      = |w_hs;
   assign w_xfer_last = |(w_hs & sti_TLAST);

   always_comb begin
      w_mux_data = '0;
      w_mux_keep = '0;
      w_mux_last = 1'b0;
      for (int s = 0; s < int'(SN); s++) begin
         if (r_grant[s]) begin
            w_mux_data = sti_TDATA[s*BW +: BW];
            w_mux_keep = sti_TKEEP[s*DN +: DN];
            w_mux_last = sti_TLAST[s];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         StIdle: begin
            if (|w_req) begin
               w_grant_nxt = w_sel;
               w_ptr_nxt   = w_sel_idx;
               w_state_nxt = StLock;
            end
         end
         StLock: begin
            // Re-arbitrate on the closing beat so back-to-back packets need no idle cycle.
            if (w_xfer_last) begin
               if (|w_req) begin
                  w_grant_nxt = w_sel;
                  w_ptr_nxt   = w_sel_idx;
               end else begin
                  w_grant_nxt = '0;
                  w_state_nxt = StIdle;
               end
            end
         end
         default: begin
            w_grant_nxt = '0;
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state <= StIdle;
         r_grant <= '0;
         r_ptr   <= IW'(SN - 1);
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   assign sts_grant = r_grant;
   assign sts_busy  = (r_state == StLock);

   axi4_stream_reg #(
      .W(OW)
   ) u_out_reg (
      .i_clk   (ACLK),
      .i_rst_n (ARESETn),
      .i_valid (w_xfer),
      .i_data  ({w_mux_last, w_mux_keep, w_mux_data}),
      .o_ready (w_slot_rdy),
      .o_valid (sto_TVALID),
      .o_data  (w_out_data),
      .i_ready (sto_TREADY)
   );

   assign {sto_TLAST, sto_TKEEP, sto_TDATA} = w_out_data;

endmodule

// File: doc/axi4_stream_arb.md
Name: axi4_stream_arb

Overview:
- Packet-granular N:1 arbiter for AXI4-Stream. Shares one downstream stream sink (DMA/ADC capture path) among SN upstream sources.
- Round-robin grant among enabled, requesting sources.
- Once a source is granted, the grant is held until that source's beat with TLAST=1 is accepted. Packets are never interleaved.
- Output is registered. No bubble between packets at full throughput.

Parameters:
- SN, 2, number of source streams (2..16).
- DN, 1, data elements per beat.
- DW, 8, bits per data element.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- sti_TDATA  in  SN*DN*DW  source data; source s occupies slice [s*DN*DW +: DN*DW].
- sti_TKEEP  in  SN*DN  source byte/element keep.
- sti_TLAST  in  SN  source last-beat flag.
- sti_TVALID  in  SN  source valid.
- sti_TREADY  out  SN  source ready.
- sto_TDATA  out  DN*DW  merged data.
- sto_TKEEP  out  DN  merged keep.
- sto_TLAST  out  1  merged last.
- sto_TVALID  out  1  merged valid.
- sto_TREADY  in  1  sink ready.
- ctl_mask  in  SN  per-source enable (1 = may be granted).
- sts_grant  out  SN  one-hot current grant; all zero when IDLE.
- sts_busy  out  1  1 while in LOCK state.

Behaviour:
- Reset (async assert, sync release): all outputs are 0.
  - sts_grant=0, sts_busy=0, sto_TVALID=0, sto_TDATA/TKEEP/TLAST=0, sti_TREADY=0.
  - Round-robin pointer ptr=SN-1, so source 0 has first priority.
- Request vector: req = sti_TVALID & ctl_mask.
- Round-robin selection: nxt = first set bit of req, searching from ptr+1 upward and wrapping modulo SN. Exactly one winner.
- FSM has two states.
  - IDLE: if req!=0, then on the next edge grant<=onehot(nxt), ptr<=nxt, state<=LOCK. If req==0, stay in IDLE.
  - LOCK: sti_TREADY[g] = grant[g] & (~sto_TVALID | sto_TREADY). All other sti_TREADY bits are 0.
  - A transfer on source g occurs when sti_TVALID[g] & sti_TREADY[g].
  - On a transfer with sti_TLAST[g]=1, re-arbitrate in the same cycle using req with bit g included. The single-source case therefore back-to-backs.
    - If req!=0, grant/ptr load nxt and the state stays LOCK.
    - Otherwise grant<=0 and state<=IDLE.
- Output register (skid-free pipeline stage):
  - On a source transfer, load sto_TDATA/TKEEP/TLAST and set sto_TVALID=1.
  - Else if sto_TREADY, clear sto_TVALID.
  - sto_* data holds its value while sto_TVALID & ~sto_TREADY.
- Latency:
  - From IDLE, the first beat appears on sto_TVALID 2 cycles after sti_TVALID rises: 1 cycle grant, 1 cycle output register.
  - Within a packet, and between packets when already in LOCK, throughput is 1 beat/cycle with sto_TREADY=1.
- Mask changes:
  - A mask change affects only the next arbitration.
  - Clearing the mask bit of the granted source mid-packet does not abort the packet; the packet completes.
- A granted source dropping TVALID mid-packet: the grant is held and the arbiter waits indefinitely. There is no timeout.
- sto_TREADY low: sti_TREADY[g] drops only when the output register is full. No beat is lost or duplicated.
- Reset mid-packet: everything returns to reset values immediately. The partial packet is discarded. No TLAST is emitted.
- Simultaneous last-beat and new requests: handled by the same-cycle re-arbitration rule above.

Decomposition:
- Shared package axi4_stream_pkg gains:
  - function rr_sel(req, ptr) returning the one-hot winner.
  - localparam for index width $clog2(SN).
- One sub-module: axi4_stream_reg (single-stage registered stream slice with ready pass-through), reused elsewhere. The arbiter instantiates it on the merged path.

Test Plan:
- SN=2, source 0 sends a 3-beat packet (data 0x11,0x22,0x33, last on 0x33), sto_TREADY=1 -> sto sees 0x11,0x22,0x33 on consecutive cycles; first beat 2 cycles after TVALID; sts_grant=01 then 00.
- Both sources continuously valid with 2-beat packets (source0 0xA0/0xA1, source1 0xB0/0xB1) -> output A0,A1,B0,B1,A0,... with no idle cycle between packets.
- sto_TREADY pattern 1,0,0,1,1 during a 4-beat packet -> every beat delivered exactly once and in order; sto_TDATA stable while TREADY=0.
- ctl_mask=10 with both sources valid -> only source 1 granted; clearing mask bit 1 mid-packet -> packet still completes, then IDLE.
- SN=4, requests on sources 3 and 0 with ptr=2 -> grant 3, then 0 (wrap-around order verified).
- ARESETn pulsed low mid-packet -> all outputs 0 asynchronously; after release, source 0 wins first and no stale TLAST appears.
